// File: rtl/eye_trk_pkg.sv
// Shared definitions for the eye tracking supervisor: supervisor states,
// tracked-coordinate width and default size thresholds (pixels).
package eye_trk_pkg;

    localparam int EYE_COORD_W = 11;

    localparam logic [EYE_COORD_W-1:0] DEF_MIN_WIDE    = 11'd8;
    localparam logic [EYE_COORD_W-1:0] DEF_MAX_WIDE    = 11'd120;
    localparam logic [EYE_COORD_W-1:0] DEF_MAX_HIGH    = 11'd60;
    localparam logic [EYE_COORD_W-1:0] DEF_CLOSED_HIGH = 11'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_LOST    = 3'd4
    } sv_state_t;

endpackage

// File: rtl/eye_box_check.sv
// Combinational plausibility check of one tracked eye box.
// Ports:
//   wide   in  tracked eye width (px, unsigned)
//   high   in  tracked eye height (px, unsigned)
//   valid  out width within [MIN_WIDE, MAX_WIDE] and height <= MAX_HIGH
//   closed out width within range and height < CLOSED_HIGH
module eye_box_check
    import eye_trk_pkg::*;
#(
    parameter logic [EYE_COORD_W-1:0] MIN_WIDE    = DEF_MIN_WIDE,
    parameter logic [EYE_COORD_W-1:0] MAX_WIDE    = DEF_MAX_WIDE,
    parameter logic [EYE_COORD_W-1:0] MAX_HIGH    = DEF_MAX_HIGH,
    parameter logic [EYE_COORD_W-1:0] CLOSED_HIGH = DEF_CLOSED_HIGH
) (
    input  logic [EYE_COORD_W-1:0] wide,
    input  logic [EYE_COORD_W-1:0] high,
    output logic                   valid,
    output logic                   closed
);

    logic wide_ok;

    assign wide_ok = (wide >= MIN_WIDE) && (wide <= MAX_WIDE);
    assign valid   = wide_ok && (high <= MAX_HIGH);
    assign closed  = wide_ok && (high < CLOSED_HIGH);

endmodule

// File: rtl/eye_track_supervisor.sv
// Eye tracker supervisor: decides when the tracker is seeded, qualifies each
// frame's tracked eye sizes, declares lock / lock loss and counts consecutive
// closed-eye frames.
// Ports:
//   module_clk, module_rst_n  clock, synchronous active-low reset
//   touch_key                 raw touch key, rising edge requests a (re)seed
//   frame_end                 one-cycle end-of-frame pulse
//   det_valid                 detector boxes currently valid
//   eye{1,2}_{wide,high}_trk  tracked eye sizes
//   seed_load                 pulse: tracker latches detector boxes
//   trk_enable                tracker result in use (ACQUIRE or TRACK)
//   eye_lock                  tracking locked
//   lost_pulse                pulse on lock loss
//   eye_closed                last evaluated TRACK frame was closed-eye
//   closed_run_cnt            consecutive closed-eye frames, saturating
//   sv_state                  current state for debug
module eye_track_supervisor
    import eye_trk_pkg::*;
#(
    parameter logic [EYE_COORD_W-1:0] MIN_WIDE    = DEF_MIN_WIDE,
    parameter logic [EYE_COORD_W-1:0] MAX_WIDE    = DEF_MAX_WIDE,
    parameter logic [EYE_COORD_W-1:0] MAX_HIGH    = DEF_MAX_HIGH,
    parameter logic [EYE_COORD_W-1:0] CLOSED_HIGH = DEF_CLOSED_HIGH,
    parameter int unsigned            ACQ_FRAMES  = 3,
    parameter int unsigned            LOST_FRAMES = 8,
    parameter bit                     AUTO_SEED   = 1'b1
) (
    input  logic                   module_clk,
    input  logic                   module_rst_n,
    input  logic                   touch_key,
    input  logic                   frame_end,
    input  logic                   det_valid,
    input  logic [EYE_COORD_W-1:0] eye1_wide_trk,
    input  logic [EYE_COORD_W-1:0] eye1_high_trk,
    input  logic [EYE_COORD_W-1:0] eye2_wide_trk,
    input  logic [EYE_COORD_W-1:0] eye2_high_trk,
    output logic                   seed_load,
    output logic                   trk_enable,
    output logic                   eye_lock,
    output logic                   lost_pulse,
    output logic                   eye_closed,
    output logic [7:0]             closed_run_cnt,
    output logic [2:0]             sv_state
);

    localparam logic [3:0] ACQ_N  = 4'(ACQ_FRAMES);
    localparam logic [3:0] LOST_N = 4'(LOST_FRAMES);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic      e1_valid, e1_closed, e2_valid, e2_closed;
    logic      fv, fc;
    logic      key_d0, key_d1, touch_en, seed_req;

    sv_state_t state, state_n;
    logic [3:0] good_cnt, good_n, bad_cnt, bad_n;
    logic       skip, skip_n, lock_n, closed_n;
    logic [7:0] run_n;

    eye_box_check #(
        .MIN_WIDE(MIN_WIDE), .MAX_WIDE(MAX_WIDE),
        .MAX_HIGH(MAX_HIGH), .CLOSED_HIGH(CLOSED_HIGH)
    ) u_eye1 (
        .wide(eye1_wide_trk), .high(eye1_high_trk),
        .valid(e1_valid), .closed(e1_closed)
    );

    eye_box_check #(
        .MIN_WIDE(MIN_WIDE), .MAX_WIDE(MAX_WIDE),
        .MAX_HIGH(MAX_HIGH), .CLOSED_HIGH(CLOSED_HIGH)
    ) u_eye2 (
        .wide(eye2_wide_trk), .high(eye2_high_trk),
        .valid(e2_valid), .closed(e2_closed)
    );

    assign fv       = e1_valid && e2_valid;
    assign fc       = e1_closed && e2_closed;
    assign touch_en = key_d0 & ~key_d1;
    assign seed_req = touch_en && det_valid;
    assign sv_state = state;

    always_comb begin
        state_n  = state;
        good_n   = good_cnt;
        bad_n    = bad_cnt;
        skip_n   = skip;
        lock_n   = eye_lock;
        closed_n = eye_closed;
        run_n    = closed_run_cnt;
        case (state)
            ST_IDLE: begin
                if (seed_req || (AUTO_SEED && frame_end && det_valid))
                    state_n = ST_SEED;
            end
            ST_SEED: begin
                good_n  = 4'd0;
                bad_n   = 4'd0;
                skip_n  = 1'b1;
                state_n = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                // A seed request beats a coincident frame evaluation.
                if (seed_req) begin
                    state_n = ST_SEED;
                    lock_n  = 1'b0;
                end else if (frame_end) begin
                    if (skip) begin
                        // Tracker output still reflects the seed boxes.
                        skip_n = 1'b0;
                    end else if (fv) begin
                        bad_n = 4'd0;
                        if (good_cnt + 4'd1 == ACQ_N) begin
                            state_n = ST_TRACK;
                            lock_n  = 1'b1;
                        end else begin
                            good_n = good_cnt + 4'd1;
                        end
                    end else begin
                        good_n = 4'd0;
                        if (bad_cnt + 4'd1 == LOST_N) begin
                            state_n  = ST_LOST;
                            lock_n   = 1'b0;
                            closed_n = 1'b0;
                            run_n    = 8'd0;
                        end else begin
                            bad_n = bad_cnt + 4'd1;
                        end
                    end
                end
            end
            ST_TRACK: begin
                if (seed_req) begin
                    state_n = ST_SEED;
                    lock_n  = 1'b0;
                end else if (frame_end) begin
                    if (fv) begin
                        bad_n    = 4'd0;
                        closed_n = fc;
                        run_n    = fc ? sat_inc8(closed_run_cnt) : 8'd0;
                    end else if (bad_cnt + 4'd1 == LOST_N) begin
                        // Outputs drop on entry so they read 0 during LOST.
                        state_n  = ST_LOST;
                        lock_n   = 1'b0;
                        closed_n = 1'b0;
                        run_n    = 8'd0;
                    end else begin
                        bad_n = bad_cnt + 4'd1;
                    end
                end
            end
            ST_LOST: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge module_clk) begin
        if (!module_rst_n) begin
            key_d0         <= 1'b0;
            key_d1         <= 1'b0;
            state          <= ST_IDLE;
            good_cnt       <= 4'd0;
            bad_cnt        <= 4'd0;
            skip           <= 1'b0;
            eye_lock       <= 1'b0;
            eye_closed     <= 1'b0;
            closed_run_cnt <= 8'd0;
            seed_load      <= 1'b0;
            lost_pulse     <= 1'b0;
            trk_enable     <= 1'b0;
        end else begin
            key_d0         <= touch_key;
            key_d1         <= key_d0;
            state          <= state_n;
            good_cnt       <= good_n;
            bad_cnt        <= bad_n;
            skip           <= skip_n;
            eye_lock       <= lock_n;
            eye_closed     <= closed_n;
            closed_run_cnt <= run_n;
            // Pulses are registered from the next state so they align with it.
            seed_load      <= (state_n == ST_SEED);
            lost_pulse     <= (state_n == ST_LOST);
            trk_enable     <= (state_n == ST_ACQUIRE) || (state_n == ST_TRACK);
        end
    end

endmodule

// File: tb/tb_eye_track_supervisor.sv
module tb_eye_track_supervisor;
    import eye_trk_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, touch_key, frame_end, det_valid;
    logic [10:0] e1w, e1h, e2w, e2h;

    logic       seed_load, trk_enable, eye_lock, lost_pulse, eye_closed;
    logic [7:0] closed_run_cnt;
    logic [2:0] sv_state;

    logic       m_seed_load, m_trk_enable, m_eye_lock, m_lost_pulse, m_eye_closed;
    logic [7:0] m_closed_run_cnt;
    logic [2:0] m_sv_state;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    eye_track_supervisor dut (
        .module_clk(clk), .module_rst_n(rst_n), .touch_key(touch_key),
        .frame_end(frame_end), .det_valid(det_valid),
        .eye1_wide_trk(e1w), .eye1_high_trk(e1h),
        .eye2_wide_trk(e2w), .eye2_high_trk(e2h),
        .seed_load(seed_load), .trk_enable(trk_enable), .eye_lock(eye_lock),
        .lost_pulse(lost_pulse), .eye_closed(eye_closed),
        .closed_run_cnt(closed_run_cnt), .sv_state(sv_state)
    );

    eye_track_supervisor #(.AUTO_SEED(1'b0)) dut_m (
        .module_clk(clk), .module_rst_n(rst_n), .touch_key(touch_key),
        .frame_end(frame_end), .det_valid(det_valid),
        .eye1_wide_trk(e1w), .eye1_high_trk(e1h),
        .eye2_wide_trk(e2w), .eye2_high_trk(e2h),
        .seed_load(m_seed_load), .trk_enable(m_trk_enable), .eye_lock(m_eye_lock),
        .lost_pulse(m_lost_pulse), .eye_closed(m_eye_closed),
        .closed_run_cnt(m_closed_run_cnt), .sv_state(m_sv_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // frame_end high across one active edge; outputs checked right after it.
    task automatic pulse_fe();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_fe();
            tick();
        end
    endtask

    // From IDLE with det_valid=1 and valid boxes: auto seed, skip, 3 valid frames.
    task automatic to_track();
        pulse_fe();
        tick();
        frames(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; touch_key = 1'b0; frame_end = 1'b0; det_valid = 1'b0;
        e1w = 11'd40; e1h = 11'd20; e2w = 11'd40; e2h = 11'd20;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_seed_load", 32'(seed_load), 32'd0);
        check("rst_eye_lock",  32'(eye_lock),  32'd0);
        check("rst_state",     32'(sv_state),  32'd0);
        check("rst_trk_en",    32'(trk_enable), 32'd0);
        check("rst_run_cnt",   32'(closed_run_cnt), 32'd0);

        // Auto seed and acquisition
        det_valid = 1'b1;
        pulse_fe();
        check("seed_state", 32'(sv_state), 32'd1);
        check("seed_load_hi", 32'(seed_load), 32'd1);
        tick();
        check("acq_state", 32'(sv_state), 32'd2);
        check("seed_load_lo", 32'(seed_load), 32'd0);
        check("acq_trk_en", 32'(trk_enable), 32'd1);
        frames(3);
        check("acq_not_locked", 32'(eye_lock), 32'd0);
        pulse_fe();
        check("lock_after_4th", 32'(eye_lock), 32'd1);
        check("track_state", 32'(sv_state), 32'd3);
        tick();

        // Loss handling: 7 bad + 1 good keeps lock, 8 bad loses it
        e1w = 11'd0;
        frames(7);
        check("7bad_locked", 32'(eye_lock), 32'd1);
        e1w = 11'd40;
        frames(1);
        check("good_restores", 32'(sv_state), 32'd3);
        e1w = 11'd0;
        frames(7);
        check("7bad_again_locked", 32'(eye_lock), 32'd1);
        pulse_fe();
        check("lost_pulse_hi", 32'(lost_pulse), 32'd1);
        check("lost_lock_lo", 32'(eye_lock), 32'd0);
        check("lost_state", 32'(sv_state), 32'd4);
        tick();
        check("lost_pulse_lo", 32'(lost_pulse), 32'd0);
        check("lost_to_idle", 32'(sv_state), 32'd0);
        e1w = 11'd40;

        // Closed-eye counting
        to_track();
        check("retrack_state", 32'(sv_state), 32'd3);
        e1h = 11'd2; e2h = 11'd2;
        frames(5);
        check("closed_flag", 32'(eye_closed), 32'd1);
        check("closed_cnt5", 32'(closed_run_cnt), 32'd5);
        e1h = 11'd20; e2h = 11'd20;
        frames(1);
        check("open_flag", 32'(eye_closed), 32'd0);
        check("open_cnt0", 32'(closed_run_cnt), 32'd0);
        e1h = 11'd2; e2h = 11'd2;
        frames(300);
        check("closed_sat", 32'(closed_run_cnt), 32'd255);

        // Reset held 2 clocks mid-TRACK
        rst_n = 1'b0;
        tick(); tick();
        check("mid_rst_state", 32'(sv_state), 32'd0);
        check("mid_rst_lock", 32'(eye_lock), 32'd0);
        check("mid_rst_closed", 32'(eye_closed), 32'd0);
        check("mid_rst_cnt", 32'(closed_run_cnt), 32'd0);
        check("mid_rst_trk", 32'(trk_enable), 32'd0);
        rst_n = 1'b1;
        e1h = 11'd20; e2h = 11'd20;
        tick();

        // Touch coincident with frame_end wins; frame evaluation dropped
        to_track();
        e1h = 11'd2; e2h = 11'd2;
        frames(3);
        check("pre_touch_cnt", 32'(closed_run_cnt), 32'd3);
        touch_key = 1'b1;
        tick();
        pulse_fe();
        check("touch_seed_state", 32'(sv_state), 32'd1);
        check("touch_lock_lo", 32'(eye_lock), 32'd0);
        check("touch_seed_load", 32'(seed_load), 32'd1);
        check("touch_cnt_hold", 32'(closed_run_cnt), 32'd3);
        touch_key = 1'b0;
        tick();
        frames(4);
        check("relock_state", 32'(sv_state), 32'd3);
        // Touch without det_valid is ignored
        det_valid = 1'b0;
        touch_key = 1'b1;
        tick(); tick(); tick();
        check("nodet_state", 32'(sv_state), 32'd3);
        check("nodet_lock", 32'(eye_lock), 32'd1);
        touch_key = 1'b0;
        det_valid = 1'b1;
        tick(); tick();

        // AUTO_SEED=0 instance: frame_end alone does not seed
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        pulse_fe();
        check("man_no_seed", 32'(m_seed_load), 32'd0);
        check("auto_seeds", 32'(seed_load), 32'd1);
        tick();
        frames(2);
        check("man_idle", 32'(m_sv_state), 32'd0);
        touch_key = 1'b1;
        tick();
        tick();
        check("man_touch_seed", 32'(m_seed_load), 32'd1);
        check("man_touch_state", 32'(m_sv_state), 32'd1);
        touch_key = 1'b0;
        tick();
        check("man_acq_state", 32'(m_sv_state), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
